// File: rtl/array_rw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : array_rw_ctrl                                                |
// | Description : Round-robin write/read arbiter for a single-port SRAM with a |
// |               credit-limited 2-entry read response FIFO. Define           |
// |               ARRAY_RW_CTRL_BYPASS_EN for a 1-cycle response bypass.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module array_rw_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_w_valid,
    output logic              io_w_ready,
    input  logic [ADDR_W-1:0] io_w_addr,
    input  logic [DATA_W-1:0] io_w_data,
    input  logic              io_r_valid,
    output logic              io_r_ready,
    input  logic [ADDR_W-1:0] io_r_addr,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [DATA_W-1:0] io_resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [1:0] c_FIFO_DEPTH = 2'd2;
    localparam logic       c_PRIO_WRITE = 1'b0;
    localparam logic       c_PRIO_READ  = 1'b1;

    logic              r_prio;
    logic              r_rd_pend;
    logic [1:0]        r_count;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [DATA_W-1:0] r_mem [0:1];

    logic       w_rd_elig;
    logic       w_contend;
    logic       w_grant_w;
    logic       w_grant_r;
    logic       w_enq;
    logic       w_deq;
    logic       w_fifo_empty;
    logic [1:0] w_used;

    // Credits are taken from registered state only, so a dequeue this cycle
    // cannot make room for a read granted in the same cycle.
    assign w_used    = r_count + {1'b0, r_rd_pend};
    assign w_rd_elig = (w_used < c_FIFO_DEPTH);
    assign w_contend = io_w_valid & io_r_valid & w_rd_elig;

    always_comb begin
        w_grant_w = 1'b0;
        w_grant_r = 1'b0;
        if (!reset) begin
            if (w_contend) begin
                w_grant_w = (r_prio == c_PRIO_WRITE);
                w_grant_r = (r_prio == c_PRIO_READ);
            end else if (io_w_valid) begin
                w_grant_w = 1'b1;
            end else if (io_r_valid && w_rd_elig) begin
                w_grant_r = 1'b1;
            end
        end
    end

    assign io_w_ready   = w_grant_w;
    assign io_r_ready   = w_grant_r;
    assign sram_en      = w_grant_w | w_grant_r;
    assign sram_wmode   = w_grant_w;
    assign sram_addr    = w_grant_w ? io_w_addr : io_r_addr;
    assign sram_wdata   = io_w_data;
    assign w_fifo_empty = (r_count == 2'd0);

`ifdef ARRAY_RW_CTRL_BYPASS_EN
    logic w_bypass;
    // Data returning into an empty FIFO is offered straight to the consumer
    // and only buffered if the consumer stalls.
    assign w_bypass      = r_rd_pend & w_fifo_empty;
    assign io_resp_valid = !reset & (!w_fifo_empty | r_rd_pend);
    assign io_resp_data  = w_fifo_empty ? sram_rdata : r_mem[r_rd_ptr];
    assign w_enq         = r_rd_pend & !(w_bypass & io_resp_ready);
`else
    assign io_resp_valid = !reset & !w_fifo_empty;
    assign io_resp_data  = r_mem[r_rd_ptr];
    assign w_enq         = r_rd_pend;
`endif

    assign w_deq = io_resp_valid & io_resp_ready & !w_fifo_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio    <= c_PRIO_WRITE;
            r_rd_pend <= 1'b0;
            r_count   <= 2'd0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
        end else begin
            r_rd_pend <= w_grant_r;
            if (w_contend) begin
                r_prio <= ~r_prio;
            end
            if (w_enq) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_enq) begin
            r_mem[r_wr_ptr] <= sram_rdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/array_rw_ctrl.md
ARRAY_RW_CTRL -- requirements
Module: array_rw_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, SRAM word address width.
REQ-002 Parameter DATA_W, default 16, SRAM word width.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_w_valid  input  1  write request valid.
REQ-006 io_w_ready  output  1  write request accepted this cycle when high with io_w_valid.
REQ-007 io_w_addr  input  ADDR_W  write address.
REQ-008 io_w_data  input  DATA_W  write data.
REQ-009 io_r_valid  input  1  read request valid.
REQ-010 io_r_ready  output  1  read request accepted this cycle when high with io_r_valid.
REQ-011 io_r_addr  input  ADDR_W  read address.
REQ-012 io_resp_valid  output  1  read response valid.
REQ-013 io_resp_ready  input  1  consumer accepts response.
REQ-014 io_resp_data  output  DATA_W  read response data.
REQ-015 sram_en  output  1  single-port SRAM access enable.
REQ-016 sram_wmode  output  1  1 = write, 0 = read.
REQ-017 sram_addr  output  ADDR_W  SRAM address.
REQ-018 sram_wdata  output  DATA_W  SRAM write data.
REQ-019 sram_rdata  input  DATA_W  SRAM read data, valid the cycle after a read access, held until the next read.

Function
REQ-020 At most one SRAM access per cycle; sram_en/sram_wmode/sram_addr/sram_wdata combinational from the granted request in the handshake cycle.
REQ-021 sram_en is 0 in any cycle with no handshake; sram_addr/sram_wdata are don't-care then.
REQ-022 Write handshake: io_w_valid & io_w_ready -> sram_en=1, sram_wmode=1, address/data passed through.
REQ-023 Read handshake: io_r_valid & io_r_ready -> sram_en=1, sram_wmode=0.
REQ-024 Response buffer: 2-entry FIFO capturing sram_rdata in cycle T+1 for a read handshake in cycle T; in-order delivery.
REQ-025 Credit rule: read eligible only when (FIFO occupancy + in-flight reads) < 2; same-cycle response dequeue does not free a credit.
REQ-026 Arbitration: single valid requester wins if eligible; when both valid and the read is eligible, round-robin priority pointer decides, then flips to the loser.
REQ-027 Ineligible read (no credit) never blocks a valid write; pointer does not flip in that case.
REQ-028 io_w_ready/io_r_ready assert only for the granted channel; both never high together.
REQ-029 Response latency: read handshake at T -> io_resp_valid at T+2 (FIFO registered); io_resp_data stable while io_resp_valid & !io_resp_ready.
REQ-030 Write at T then read of same address at T+1 returns the newly written data.
REQ-031 Simultaneous FIFO enqueue and dequeue keeps occupancy unchanged; full FIFO never overflows (guaranteed by REQ-025).

Reset
REQ-032 During reset: io_w_ready=0, io_r_ready=0, io_resp_valid=0, sram_en=0.
REQ-033 After reset: FIFO empty, in-flight count 0, priority pointer = write.
REQ-034 Reset mid-operation discards in-flight reads and buffered responses; none delivered afterwards.

Configuration
REQ-035 Macro ARRAY_RW_CTRL_BYPASS_EN.
REQ-036 Defined: when FIFO empty and a read completes at T+1, io_resp_valid=1 and io_resp_data=sram_rdata at T+1 (latency 1); enqueue into FIFO only if io_resp_ready=0 at T+1.
REQ-037 Undefined: no bypass path; latency exactly 2 per REQ-029; credit rule unchanged in both builds.

Verification
REQ-038 Write addr 0x005 data 0xA5A5 at T, read addr 0x005 at T+1, resp_ready=1 -> resp_data=0xA5A5 at T+3 (T+2 with bypass).
REQ-039 io_w_valid and io_r_valid held high for 4 cycles after reset -> grants W,R,W,R; sram_wmode 1,0,1,0.
REQ-040 io_resp_ready=0, 3 back-to-back reads of 0x001/0x002/0x003 -> only 2 accepted, io_r_ready=0 afterwards; after ready=1 responses arrive in order, third read then accepted.
REQ-041 Credits exhausted with io_w_valid=1 and io_r_valid=1 -> writes granted every cycle, pointer unchanged.
REQ-042 Reset asserted cycle after a read handshake -> io_resp_valid stays 0 for all cycles after reset until a new read.
REQ-043 Idle (no valids) for 10 cycles -> sram_en=0 throughout, io_resp_valid=0.
